// File: rtl/shift_link_tx.sv
// shift_link_tx: parallel-in, serial-out link transmitter.
// Takes words over a load/ready handshake, holds one word ahead of the
// shifter, and sends each frame (data bits plus optional even parity) on sio
// with an optional forced idle gap between frames.
module shift_link_tx #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned LSB_FIRST = 0,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned GAP       = 0
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             sio,
  output logic             frame,
  output logic             done,
  output logic             busy
);

  localparam int unsigned NBITS = WIDTH + PARITY;
  localparam int unsigned CW    = $clog2(NBITS + 1);
  localparam int unsigned GW    = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [CW-1:0] LastBit = CW'(NBITS - 1);
  localparam logic [GW-1:0] GapLast = GW'((GAP > 0) ? (GAP - 1) : 0);

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  state_e             state_q, state_d;
  logic [NBITS-1:0]   shreg_q, shreg_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic [WIDTH-1:0]   hold_q, hold_d;
  logic               hold_valid_q, hold_valid_d;
  logic               sio_q, sio_d;
  logic               frame_q, frame_d;
  logic               done_q, done_d;

  logic               accept;
  logic               start_hold;
  logic               start_in;
  logic [NBITS-1:0]   shreg_next;

  // Frame image: the bit sent first sits at the end the shifter drains from
  // (MSB end for MSB-first, LSB end for LSB-first); parity sits at the far end.
  function automatic logic [NBITS-1:0] build_frame(input logic [WIDTH-1:0] d);
    logic [NBITS-1:0] f;
    f = '0;
    if (LSB_FIRST != 0) begin
      f[WIDTH-1:0] = d;
      if (PARITY != 0) f[NBITS-1] = ^d;
    end else begin
      f[NBITS-1 -: WIDTH] = d;
      if (PARITY != 0) f[0] = ^d;
    end
    return f;
  endfunction

  assign shreg_next = (LSB_FIRST != 0) ? {1'b0, shreg_q[NBITS-1:1]}
                                       : {shreg_q[NBITS-2:0], 1'b0};

  // Next-state, shifter, hold buffer and registered-output decode.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    gap_d        = gap_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    start_hold   = 1'b0;
    start_in     = 1'b0;
    accept       = load && !hold_valid_q;

    unique case (state_q)
      StIdle: begin
        if (hold_valid_q) start_hold = 1'b1;
        else if (accept)  start_in   = 1'b1;
      end
      StShift: begin
        if (cnt_q != LastBit) begin
          cnt_d   = cnt_q + CW'(1);
          shreg_d = shreg_next;
        end else if (GAP != 0) begin
          state_d = StGap;
          gap_d   = '0;
        end else if (hold_valid_q) begin
          start_hold = 1'b1;
        end else if (accept) begin
          start_in = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          if (hold_valid_q) start_hold = 1'b1;
          else if (accept)  start_in   = 1'b1;
          else              state_d    = StIdle;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Hold is never full while a new word is accepted, so these are exclusive.
    if (start_hold) begin
      shreg_d      = build_frame(hold_q);
      cnt_d        = '0;
      hold_valid_d = 1'b0;
      state_d      = StShift;
    end else if (start_in) begin
      shreg_d = build_frame(data_in);
      cnt_d   = '0;
      state_d = StShift;
    end else if (accept) begin
      hold_d       = data_in;
      hold_valid_d = 1'b1;
    end

    frame_d = (state_d == StShift);
    sio_d   = 1'b0;
    if (state_d == StShift) begin
      sio_d = (LSB_FIRST != 0) ? shreg_d[0] : shreg_d[NBITS-1];
    end
    done_d  = (state_d == StShift) && (cnt_d == LastBit);
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q      <= StIdle;
      shreg_q      <= '0;
      cnt_q        <= '0;
      gap_q        <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      sio_q        <= 1'b0;
      frame_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      gap_q        <= gap_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      sio_q        <= sio_d;
      frame_q      <= frame_d;
      done_q       <= done_d;
    end
  end

  assign ready = !hold_valid_q;
  assign sio   = sio_q;
  assign frame = frame_q;
  assign done  = done_q;
  assign busy  = (state_q != StIdle);

endmodule

// File: doc/shift_link_tx.md
Name: shift_link_tx

Overview:
Parametrised serializer, successor to the fixed 8-bit shift-out plus external enabler pair. It accepts parallel words over a valid/ready handshake and buffers one word ahead. It emits each word serially on sio with its own bit counter, so no external enable timing is needed. Configurable width, bit order, optional even-parity bit and inter-frame gap. It drives the existing serial-in receiver side of the link.

Parameters:
- WIDTH, 8, data word width in bits (≥2).
- LSB_FIRST, 0, 0 = MSB transmitted first; 1 = LSB first.
- PARITY, 0, 0 = none; 1 = append one even-parity bit after the data bits.
- GAP, 0, idle cycles forced between consecutive frames (0–15).

Ports:
- clk, input, 1, rising-edge clock.
- clr_n, input, 1, asynchronous active-low reset.
- data_in, input, WIDTH, parallel word to send.
- load, input, 1, word valid; accepted on an edge where load && ready.
- ready, output, 1, holding buffer empty (combinational = !hold_valid).
- sio, output, 1, serial data, registered.
- frame, output, 1, high every cycle sio carries a frame bit, registered.
- done, output, 1, high during the cycle the last bit of a frame is on sio.
- busy, output, 1, high in SHIFT or GAP state.

Behaviour:
- Reset (clr_n low, asynchronous):
  - sio=0, frame=0, done=0, busy=0, hold_valid=0 (ready=1).
  - Shift register, bit counter and gap counter are cleared; state=IDLE.
  - Reset mid-frame aborts the frame. No done is produced.
- Frame length: NBITS = WIDTH + PARITY. Bit counter width is $clog2(NBITS+1).
- States:
  - IDLE: sio=0, frame=0.
  - SHIFT: frame=1; sio = current bit.
  - GAP: sio=0, frame=0; lasts exactly GAP cycles.
- Accept rules:
  - In IDLE with hold empty, an accepted word bypasses the hold buffer. On that edge it loads the shift register, state goes to SHIFT, and the first bit appears on sio after that edge. Latency from accept edge to first bit is 1 cycle.
  - Otherwise an accepted word goes to the hold buffer (hold_valid=1, ready=0).
  - In IDLE with hold_valid, the shift register loads from hold on the next edge.
- SHIFT:
  - One bit per cycle: MSB-first shifts left, LSB-first shifts right.
  - Parity bit = XOR of all data bits. It is computed at shift-load time and is sent after the last data bit.
  - done=1 in the cycle the bit with index NBITS-1 is on sio.
- End of frame (edge that ends the done cycle):
  - If GAP>0, go to GAP. The next frame starts after GAP cycles, loaded from hold if valid.
  - If GAP==0 and hold_valid, load from hold and stay in SHIFT. frame stays high with no bubble, and hold_valid clears (ready=1 next cycle).
  - If GAP==0, hold empty, and load is asserted on this same edge, the word bypasses into the shift register with no bubble.
  - Otherwise go to IDLE.
- Simultaneous events:
  - With hold_valid, ready=0, so a new load cannot collide with the hold→shift transfer.
  - load while in GAP fills hold; hold is consumed when GAP expires.
- data_in is sampled only on the accept edge. Later changes have no effect.
- busy=0 only in IDLE.

Test Plan:
- WIDTH=8, MSB-first: load 8'hC3 from IDLE → sio = 1,1,0,0,0,0,1,1 over 8 cycles starting the cycle after accept; frame high exactly 8 cycles; done high on the 8th; then IDLE with sio=0, busy=0.
- LSB_FIRST=1: load 8'h01 → sio = 1,0,0,0,0,0,0,0; load 8'h80 → seven 0s then 1.
- GAP=0, back-to-back: load 8'hC3, then 8'h5A on the next cycle → ready low from the 5A accept until the first bit of 5A is on sio; frame continuously high 16 cycles; sio = 11000011 01011010; two done pulses 8 cycles apart.
- GAP=2, same stimulus → frame low for exactly 2 cycles between frames, with sio=0 and busy=1 during them.
- PARITY=1: 8'h07 → 9 bits, 9th = 1, done on the 9th; 8'hC3 → 9th = 0.
- Reset mid-frame: assert clr_n low after 3 bits of 8'hFF, between clock edges → sio, frame, busy and done drop immediately, ready=1, no done pulse. After release, load 8'hA5 → clean full frame 10100101.
